// File: rtl/normalize_round_pack_f64.sv
// Normalize, range-check, denormalize (jam) and round-to-nearest-even pack of a double result.
// Optional sticky exception flags are built only when NRP_EXC_FLAGS_EN is defined.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for ap_start; operands latched on acceptance
// S_NORM  | shift significand left one bit per cycle until bit62 set
// S_RANGE | overflow / subnormal decision
// S_JAM   | right-shift with sticky for subnormal results
// S_ROUND | round-to-nearest-even and pack
// S_DONE  | result valid, ap_done/ap_ready pulse
module normalize_round_pack_f64 #(
    parameter int JAM_STEP = 1
) (
    input  logic        ap_clk,
    input  logic        ap_rst_n,
    input  logic        ap_start,
    output logic        ap_done,
    output logic        ap_idle,
    output logic        ap_ready,
    input  logic        zSign,
    input  logic [12:0] zExp,
    input  logic [63:0] zSig,
    input  logic        flags_clr,
    output logic [63:0] ap_return,
    output logic [4:0]  float_exception_flags
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_NORM,
        S_RANGE,
        S_JAM,
        S_ROUND,
        S_DONE
    } state_t;

    localparam logic [6:0] LP_STEP = 7'(JAM_STEP);

    state_t             r_state;
    state_t             w_next;
    logic               r_sign;
    logic signed [12:0] r_exp;
    logic [63:0]        r_sig;
    logic [6:0]         r_rem;
    logic               r_tiny;
    logic [4:0]         r_op_flags;
    logic [63:0]        r_return;

    logic [64:0]        w_sum;
    logic               w_norm_done;
    logic               w_ovf;
    logic               w_neg;
    logic [12:0]        w_neg_exp;
    logic [6:0]         w_rem_init;
    logic [6:0]         w_shamt;
    logic [6:0]         w_rem_next;
    logic [63:0]        w_jam_mask;
    logic [63:0]        w_jam_sig;
    logic [54:0]        w_m;
    logic [10:0]        w_exp_rnd;
    logic               w_inexact;
    logic [63:0]        w_round_result;
    logic               w_unused_sum;

    assign w_sum       = {1'b0, r_sig} + 65'h200;
    // A latched bit63 means the caller supplied an already-wide value: no normalization.
    assign w_norm_done = r_sig[63] || r_sig[62] || (r_sig == 64'd0);
    assign w_ovf       = (r_exp > 13'sd2045) || ((r_exp == 13'sd2045) && w_sum[63]);
    assign w_neg       = r_exp[12];
    assign w_neg_exp   = -r_exp;
    assign w_rem_init  = (w_neg_exp > 13'd64) ? 7'd64 : w_neg_exp[6:0];

    assign w_shamt     = (r_rem < LP_STEP) ? r_rem : LP_STEP;
    assign w_rem_next  = r_rem - w_shamt;
    assign w_jam_mask  = ~({64{1'b1}} << w_shamt);
    assign w_jam_sig   = (r_sig >> w_shamt) | {63'd0, |(r_sig & w_jam_mask)};

    // Tie (exact half) clears the LSB so the result lands on the even neighbour.
    assign w_m         = {w_sum[64:11], w_sum[10] & (r_sig[9:0] != 10'h200)};
    assign w_exp_rnd   = (w_m == 55'd0) ? 11'd0 : r_exp[10:0];
    assign w_inexact   = (r_sig[9:0] != 10'd0);
    assign w_round_result = {r_sign, 63'd0} + {1'b0, w_exp_rnd, 52'd0} + {9'd0, w_m};
    assign w_unused_sum   = ^w_sum[9:0];

    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (ap_start) w_next = S_NORM;
            S_NORM:  if (w_norm_done) w_next = S_RANGE;
            S_RANGE: begin
                if (w_ovf) begin
                    w_next = S_DONE;
                end else if (w_neg) begin
                    w_next = S_JAM;
                end else begin
                    w_next = S_ROUND;
                end
            end
            S_JAM:   if (w_rem_next == 7'd0) w_next = S_ROUND;
            S_ROUND: w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            r_sign     <= 1'b0;
            r_exp      <= 13'sd0;
            r_sig      <= 64'd0;
            r_rem      <= 7'd0;
            r_tiny     <= 1'b0;
            r_op_flags <= 5'd0;
            r_return   <= 64'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (ap_start) begin
                        r_sign <= zSign;
                        r_exp  <= zExp;
                        r_sig  <= zSig;
                        r_tiny <= 1'b0;
                    end
                end
                S_NORM: begin
                    if (!w_norm_done) begin
                        r_sig <= r_sig << 1;
                        r_exp <= r_exp - 13'sd1;
                    end
                end
                S_RANGE: begin
                    if (w_ovf) begin
                        r_return   <= {r_sign, 11'h7FF, 52'd0};
                        r_op_flags <= 5'b00101;
                    end else if (w_neg) begin
                        r_tiny <= (r_exp < -13'sd1) || !(w_sum[64] || w_sum[63]);
                        r_rem  <= w_rem_init;
                    end
                end
                S_JAM: begin
                    r_sig <= w_jam_sig;
                    r_rem <= w_rem_next;
                    if (w_rem_next == 7'd0) begin
                        r_exp <= 13'sd0;
                    end
                end
                S_ROUND: begin
                    r_return   <= w_round_result;
                    r_op_flags <= {3'b000, r_tiny & w_inexact, w_inexact};
                end
                default: begin
                end
            endcase
        end
    end

    assign ap_done   = (r_state == S_DONE);
    assign ap_ready  = ap_done;
    assign ap_idle   = (r_state == S_IDLE) && !ap_start;
    assign ap_return = r_return;

`ifdef NRP_EXC_FLAGS_EN
    logic [4:0] r_flags;

    // A clear that coincides with a completion keeps only that operation's flags.
    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            r_flags <= 5'd0;
        end else if (r_state == S_DONE) begin
            r_flags <= flags_clr ? r_op_flags : (r_flags | r_op_flags);
        end else if (flags_clr) begin
            r_flags <= 5'd0;
        end
    end

    assign float_exception_flags = r_flags;
`else
    logic w_unused_flags;

    assign w_unused_flags        = ^{flags_clr, r_op_flags};
    assign float_exception_flags = 5'd0;
`endif

endmodule
